// File: rtl/alu_mc_pkg.sv
// ---------------------------------------------------------------------------
// alu_mc_pkg
// Shared definitions for the multi-cycle saturating ALU:
//   - 4-bit operation codes
//   - controller state encoding
//   - helpers that return the signed saturation limits for a given width
// ---------------------------------------------------------------------------
package alu_mc_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_LHB = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  // Widest datapath the limit helpers can describe.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Largest signed value of a w-bit word (0111..1), zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] sat_max(input int w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

  // Smallest signed value of a w-bit word (100..0), zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] sat_min(input int w);
    return MAX_W'(1) << (w - 1);
  endfunction

  // Operations whose result can overflow and therefore own ov/ne.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/seq_mul_sat.sv
// ---------------------------------------------------------------------------
// seq_mul_sat
// Iterative signed shift-add multiplier with saturation to WIDTH bits.
// One multiplier bit is consumed per cycle; the last (sign) bit carries a
// negative weight, so the 2*WIDTH accumulator holds the exact two's-
// complement product after WIDTH iterations.
//
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset, aborts a running multiply
//   start  in   load a/b and begin (ignored while busy is never overlapped)
//   a, b   in   signed operands, sampled on the start edge
//   done   out  high during the cycle of the final iteration; prod/ovf
//                are valid in that same cycle
//   prod   out  product clamped to [SMIN, SMAX]
//   ovf    out  product did not fit in WIDTH signed bits
// ---------------------------------------------------------------------------
module seq_mul_sat
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));

  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_acc;
  logic [PW-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;

  logic          w_last;
  logic [PW-1:0] w_acc_next;
  logic          w_fits;

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // NOTE: always_comb assigns a default before any conditional update so no
  // path leaves the signal unassigned, which would infer a latch.
  always_comb begin
    w_acc_next = r_acc;
    if (r_mplier[0]) begin
      // Sign bit of b has weight -2^(WIDTH-1): subtract instead of add.
      w_acc_next = w_last ? (r_acc - r_mcand) : (r_acc + r_mcand);
    end
  end

  // Fits when the upper WIDTH+1 bits are a pure sign extension.
  assign w_fits = (&w_acc_next[PW-1:WIDTH-1]) | ~(|w_acc_next[PW-1:WIDTH-1]);
  assign done   = r_busy & w_last;
  assign ovf    = ~w_fits;
  assign prod   = w_fits ? w_acc_next[WIDTH-1:0]
                         : (w_acc_next[PW-1] ? SMIN : SMAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{a[WIDTH-1]}}, a};
      r_mplier <= b;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mc_sat.sv
// ---------------------------------------------------------------------------
// alu_mc_sat
// Multi-cycle saturating ALU with valid/ready handshakes and a committed
// flag file. Single-cycle ops present their result the cycle after accept;
// MUL runs the iterative multiplier for WIDTH cycles. Flags update only when
// the consumer takes the result. WIDTH must be even and at least 4.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset (aborts MUL)
//   in_valid   in   operation offered
//   in_ready   out  operation can be accepted this cycle
//   op         in   operation code (alu_mc_pkg::OP_*)
//   src0       in   operand A
//   src1       in   operand B / shift source
//   shamt      in   shift amount
//   upd_zr     in   this operation updates zr
//   out_valid  out  result available
//   out_ready  in   consumer takes result
//   dst        out  result (held stable while out_valid & ~out_ready)
//   ov, zr, ne out  committed overflow / zero / negative flags
// ---------------------------------------------------------------------------
module alu_mc_sat
  import alu_mc_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src0,
  input  logic [WIDTH-1:0] src1,
  input  logic [SHW-1:0]   shamt,
  input  logic             upd_zr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dst,
  output logic             ov,
  output logic             zr,
  output logic             ne
);

  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));

  state_t r_state;
  state_t w_next_state;

  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_src0;
  logic [WIDTH-1:0] r_src1;
  logic [SHW-1:0]   r_shamt;
  logic             r_upd_zr;
  logic [WIDTH-1:0] r_mul_res;
  logic             r_mul_ovf;
  logic             r_ov;
  logic             r_zr;
  logic             r_ne;

  logic             w_accept;
  logic             w_commit;
  logic             w_in_is_mul;
  logic             w_mul_start;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_prod;
  logic             w_mul_ovf;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic [WIDTH-1:0] w_clamp;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ovf;
  logic [WIDTH-1:0] w_dst;
  logic             w_res_ovf;
  logic             w_known_op;

  // -------------------------------------------------------------------------
  // Handshake / FSM
  // -------------------------------------------------------------------------
  assign w_in_is_mul = (op == OP_MUL);
  assign w_accept    = in_valid & in_ready;
  assign w_commit    = out_valid & out_ready;
  assign w_mul_start = w_accept & w_in_is_mul;

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next_state = w_in_is_mul ? ST_MUL : ST_DONE;
        end
      end
      ST_MUL: begin
        if (w_mul_done) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          // Back-to-back: the slot frees in the same cycle it is drained.
          in_ready     = 1'b1;
          w_next_state = in_valid ? (w_in_is_mul ? ST_MUL : ST_DONE) : ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Single-cycle datapath, evaluated on the captured operands so dst stays
  // stable under backpressure.
  // -------------------------------------------------------------------------
  assign w_sum     = r_src0 + r_src1;
  assign w_diff    = r_src0 - r_src1;
  assign w_add_ovf = (r_src0[WIDTH-1] == r_src1[WIDTH-1]) &
                     (w_sum[WIDTH-1]  != r_src0[WIDTH-1]);
  // A - B overflows when the operands differ in sign and the result takes
  // B's sign; equivalent to the add rule applied to -B without the -SMIN trap.
  assign w_sub_ovf = (r_src0[WIDTH-1] != r_src1[WIDTH-1]) &
                     (w_diff[WIDTH-1] != r_src0[WIDTH-1]);
  // On add/sub overflow the true result always has the sign of src0.
  assign w_clamp   = r_src0[WIDTH-1] ? SMIN : SMAX;

  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    unique case (r_op)
      OP_ADD: begin
        w_alu_res = w_add_ovf ? w_clamp : w_sum;
        w_alu_ovf = w_add_ovf;
      end
      OP_SUB: begin
        w_alu_res = w_sub_ovf ? w_clamp : w_diff;
        w_alu_ovf = w_sub_ovf;
      end
      OP_LHB: w_alu_res = {r_src1[WIDTH-1:WIDTH/2], r_src0[WIDTH/2-1:0]};
      OP_AND: w_alu_res = r_src0 & r_src1;
      OP_NOR: w_alu_res = ~(r_src0 | r_src1);
      OP_SLL: w_alu_res = r_src1 << r_shamt;
      OP_SRL: w_alu_res = r_src1 >> r_shamt;
      OP_SRA: w_alu_res = $signed(r_src1) >>> r_shamt;
      default: begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
      end
    endcase
  end

  assign w_dst      = (r_op == OP_MUL) ? r_mul_res : w_alu_res;
  assign w_res_ovf  = (r_op == OP_MUL) ? r_mul_ovf : w_alu_ovf;
  assign w_known_op = (r_op <= OP_MUL);

  // -------------------------------------------------------------------------
  // Multiplier
  // -------------------------------------------------------------------------
  seq_mul_sat #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk  (clk),
    .rst  (rst),
    .start(w_mul_start),
    .a    (src0),
    .b    (src1),
    .done (w_mul_done),
    .prod (w_mul_prod),
    .ovf  (w_mul_ovf)
  );

  // -------------------------------------------------------------------------
  // State, operand capture, MUL result and flag file
  // -------------------------------------------------------------------------
  // Operands are reset as well so dst reads 0 (ADD of 0 and 0) after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_ADD;
      r_src0    <= '0;
      r_src1    <= '0;
      r_shamt   <= '0;
      r_upd_zr  <= 1'b0;
      r_mul_res <= '0;
      r_mul_ovf <= 1'b0;
      r_ov      <= 1'b0;
      r_zr      <= 1'b0;
      r_ne      <= 1'b0;
    end else begin
      r_state <= w_next_state;

      if (w_accept) begin
        r_op     <= op;
        r_src0   <= src0;
        r_src1   <= src1;
        r_shamt  <= shamt;
        r_upd_zr <= upd_zr;
      end

      if (w_mul_done) begin
        r_mul_res <= w_mul_prod;
        r_mul_ovf <= w_mul_ovf;
      end

      // Commit uses the op being drained; a same-edge accept only replaces
      // the captured operands for the next result.
      if (w_commit && w_known_op) begin
        if (is_arith(r_op)) begin
          r_ov <= w_res_ovf;
          r_ne <= w_dst[WIDTH-1];
        end
        if (r_upd_zr) begin
          r_zr <= ~(|w_dst);
        end
      end
    end
  end

  assign dst = w_dst;
  assign ov  = r_ov;
  assign zr  = r_zr;
  assign ne  = r_ne;

endmodule
